// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio shared definitions.
// MMIO addresses, STAT layout and the STAT packing helper.
package dmem_mmio_pkg;

    localparam logic [31:0] ADDR_CNT  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_TXD  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_STAT = 32'hFFFF_0008;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 3;

    function automatic logic [31:0] pack_stat(
        input logic                full,
        input logic                empty,
        input logic                ovf,
        input logic [ST_CNT_W-1:0] cnt
    );
        logic [31:0] s;
        s = '0;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_OVF]   = ovf;
        s[ST_CNT_LSB +: ST_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// dmem_mmio debug TX FIFO.
// Synchronous FIFO; head is presented combinationally, 0 when empty.
module dmem_mmio_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       ready,
    output logic [W-1:0]               rdata,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  buf_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          pop;
    logic          wr_en;

    assign valid = (cnt_q != '0);
    assign empty = !valid;
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign pop   = valid && ready;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign rdata = valid ? buf_q[rd_ptr] : '0;

    // Storage write; contents need no reset since valid gates the head.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            buf_q[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !wr_en) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus cycle counter, TX FIFO and STAT MMIO.
// Reads are combinational; all state changes on the rising clock edge.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  we,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] widx;
    logic          ram_hit;
    logic          cnt_hit;
    logic          txd_hit;
    logic          stat_hit;

    logic [31:0]   cnt_q;
    logic [31:0]   cnt_nxt;

    logic          ovf_q;
    logic          ovf_clr;
    logic          push;
    logic          f_full;
    logic          f_empty;
    logic          f_drop;
    logic [CW-1:0] f_count;
    logic [31:0]   stat;

    assign widx     = daddr[AW+1:2];
    assign ram_hit  = (daddr[31:AW+2] == '0);
    assign cnt_hit  = (daddr[31:2] == ADDR_CNT[31:2]);
    assign txd_hit  = (daddr[31:2] == ADDR_TXD[31:2]);
    assign stat_hit = (daddr[31:2] == ADDR_STAT[31:2]);

    assign push    = txd_hit && we[0];
    assign ovf_clr = stat_hit && we[0] && dwdata[ST_OVF];

    // Byte-lane RAM write; writes are discarded while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[widx][8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end
    end

    assign cnt_nxt = (cnt_hit && (we != 4'b0000)) ? '0 : cnt_q + 32'd1;

    // Free-running cycle counter; a CNT write clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    // Sticky overflow; a dropped push beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (f_drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    dmem_mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (dwdata[7:0]),
        .ready (tx_ready),
        .rdata (tx_data),
        .valid (tx_valid),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count),
        .drop  (f_drop)
    );

    assign stat = pack_stat(f_full, f_empty, ovf_q, ST_CNT_W'(f_count));

    // Read mux; TXD and unmapped addresses read as zero.
    always_comb begin
        drdata = '0;
        unique case (1'b1)
            ram_hit:  drdata = mem[widx];
            cnt_hit:  drdata = cnt_q;
            stat_hit: drdata = stat;
            default:  drdata = '0;
        endcase
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory subsystem directly downstream of the pipelined CPU's MEM stage.
- Consumes the CPU's daddr/dwdata/we and returns drdata in the same cycle.
- Contains a word-organised RAM with per-byte write enables, plus three memory-mapped peripherals:
  - a free-running cycle counter;
  - a 4-entry debug TX FIFO with a valid/ready output port;
  - a status register.

Parameters:
- DEPTH, 1024, RAM depth in 32-bit words (power of two).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- daddr  input  32  byte address from CPU MEM stage.
- dwdata  input  32  write data, already lane-aligned by CPU.
- we  input  4  per-byte write enable; 4'b0000 = read/no write.
- drdata  output  32  read data, combinational from daddr.
- tx_data  output  8  head-of-FIFO byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts head byte this cycle.

Behaviour:
- Address decode, using daddr[1:0] ignored (word-aligned):
  - RAM: daddr < DEPTH*4, word index daddr[log2(DEPTH)+1:2].
  - CNT 0xFFFF_0000: cycle counter, read; any write clears it.
  - TXD 0xFFFF_0004: FIFO push, write-only; reads return 0.
  - STAT 0xFFFF_0008, read bits:
    - bit0 full;
    - bit1 empty;
    - bit2 overflow (sticky);
    - bits[6:4] count (0..FIFO_DEPTH);
    - other bits 0.
  - Any other address: reads return 32'h0, writes ignored.
- Reads are combinational, zero latency:
  - RAM read is asynchronous.
  - Peripheral reads return current registered values. A write at the same address in the same cycle is not visible until the next cycle.
- RAM write: on posedge clk, each byte lane i with we[i]=1 is updated; other lanes keep their value. RAM contents are not reset.
- Cycle counter:
  - 32-bit, increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0.
  - A write to CNT (any we bit set) forces next value to 0; the clear wins over the increment.
- FIFO push: write to TXD with we[0]=1 pushes dwdata[7:0]. Writes with we[0]=0 are ignored.
- FIFO pop: occurs when tx_valid && tx_ready.
- Simultaneous push and pop:
  - Not full: both occur, count unchanged.
  - Full: both occur, no overflow, count stays FIFO_DEPTH.
  - Empty: push occurs, pop impossible (tx_valid=0); tx_valid rises next cycle (no bypass).
- Push when full with no pop: data is dropped, overflow is set, FIFO is unchanged.
- Overflow clear: writing STAT with we[0]=1 and dwdata[2]=1 clears overflow. If a dropped push happens the same cycle, set wins.
- tx_data is the head entry when tx_valid=1 and holds 8'h00 when empty. Head, valid and count must stay stable while tx_ready=0.
- Pointers wrap modulo FIFO_DEPTH. count is a separate (log2(FIFO_DEPTH)+1)-bit register or is derived from extended pointers.
- Reset values (asynchronous, immediate on reset assertion, including mid-operation):
  - counter 0;
  - FIFO empty, pointers 0;
  - overflow 0;
  - tx_valid 0, tx_data 8'h00.
  - drdata then reflects reset state: STAT reads 32'h0000_0002.
  - Pending writes in the reset cycle are discarded.

Decomposition:
- Shared package: address constants ADDR_CNT, ADDR_TXD, ADDR_STAT; STAT bit positions (ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_CNT_LSB=4).
- One natural sub-module: tx_fifo, a synchronous FIFO with push/pop, full/empty/count, parameterised on FIFO_DEPTH and width 8.
- Decode, RAM, counter and the drdata mux stay in the top level.

Test Plan:
- Reset, then store word 0xDEADBEEF to 0x10 with we=4'hF; store 0x55 with we=4'b0010 -> reading 0x10 returns 0xDEAD55EF in the same cycle as daddr is applied.
- After reset, hold no writes for 10 cycles -> CNT reads 10. Write CNT -> next cycle reads 0, following cycle reads 1. Preload near wrap by free-running 2^32 or forcing -> 0xFFFF_FFFF wraps to 0.
- tx_ready=0; push 0x41,0x42,0x43,0x44 -> STAT=0x0000_0041 (count 4, full). Fifth push 0x45 -> STAT bit2=1, count 4. Raise tx_ready -> tx_data sequence 0x41..0x44, then tx_valid=0, STAT=0x0000_0006.
- FIFO full with tx_ready=1 and push 0x99 in the same cycle -> overflow stays 0, count stays 4, 0x99 is emitted last.
- Write STAT with dwdata=0x4 -> overflow cleared. Repeat with a simultaneous full push and no pop -> overflow remains 1.
- Assert reset mid-stream with FIFO count 3 and counter 500 -> tx_valid drops immediately, STAT=0x2, CNT=0. RAM word 0x10 retains 0xDEAD55EF.
